// File: rtl/cpu_types_pkg.sv
// Shared CPU types: sequential ALU opcodes, FSM states, iterative-op helper.
// SEQ_ALU_DIV_EN adds DIVU/REMU to the set of iterative operations.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        SLL  = 4'd0,
        SRL  = 4'd1,
        SRA  = 4'd2,
        ADD  = 4'd3,
        SUB  = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        NOR  = 4'd8,
        SLT  = 4'd9,
        SLTU = 4'd10,
        MULU = 4'd11,
        DIVU = 4'd12,
        REMU = 4'd13
    } seqaluop_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } seq_alu_state_t;

    function automatic logic is_iter_op(seqaluop_t o);
`ifdef SEQ_ALU_DIV_EN
        return (o == MULU) || (o == DIVU) || (o == REMU);
`else
        return (o == MULU);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift-register engine: shift-add multiply, restoring divide.
// Divide datapath exists only when SEQ_ALU_DIV_EN is defined.
import cpu_types_pkg::*;

module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_lo, step_hi;
`ifdef SEQ_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   shifted, trial;
`endif

    // One iteration step; results of the final step are taken directly.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, opb_q};
        if (div_q) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        opb_d  = opb_q;
`ifdef SEQ_ALU_DIV_EN
        div_d  = div_q;
`endif
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(WIDTH - 1);
            lo_d   = opa;
            hi_d   = '0;
            opb_d  = opb;
`ifdef SEQ_ALU_DIV_EN
            div_d  = div_mode;
`endif
        end else if (busy_q) begin
            lo_d  = step_lo;
            hi_d  = step_hi;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            opb_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            opb_q  <= opb_d;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == '0);
    assign res_lo = step_lo;
    assign res_hi = step_hi;

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU with iterative unsigned multiply.
// Define SEQ_ALU_DIV_EN to add DIVU/REMU (restoring divide).
import cpu_types_pkg::*;

module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             div0
);

    seq_alu_state_t   state_q, state_d;
    seqaluop_t        op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic             neg_q, neg_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, div0_q, div0_d;

    logic             accept, iter_start, iter_busy, iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;
    logic [WIDTH-1:0] sum, diff, res_lo, res_hi;
    logic             res_ovf, res_div0;
    logic [SHAMT_W-1:0] shamt;

    assign accept     = in_valid && (state_q == IDLE);
    assign iter_start = accept && is_iter_op(seqaluop_t'(op));

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (CLK),
        .rst      (RST),
        .start    (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .div_mode (seqaluop_t'(op) != MULU),
`endif
        .opa      (porta),
        .opb      (portb),
        .busy     (iter_busy),
        .done     (iter_done),
        .res_lo   (iter_lo),
        .res_hi   (iter_hi)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (!is_iter_op(op_q) || (iter_busy && iter_done)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out       = out_q;
        out_hi    = out_hi_q;
        negative  = neg_q;
        zero      = zero_q;
        overflow  = ovf_q;
        div0      = div0_q;
    end

    always_comb begin
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        if (accept) begin
            op_d = seqaluop_t'(op);
            a_d  = porta;
            b_d  = portb;
        end
    end

    always_comb begin
        shamt    = b_q[SHAMT_W-1:0];
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        res_lo   = '0;
        res_hi   = '0;
        res_ovf  = 1'b0;
        res_div0 = 1'b0;
        case (op_q)
            SLL:  res_lo = a_q << shamt;
            SRL:  res_lo = a_q >> shamt;
            SRA:  res_lo = $signed(a_q) >>> shamt;
            ADD: begin
                res_lo  = sum;
                res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            SUB: begin
                res_lo  = diff;
                res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            AND:  res_lo = a_q & b_q;
            OR:   res_lo = a_q | b_q;
            XOR:  res_lo = a_q ^ b_q;
            NOR:  res_lo = ~(a_q | b_q);
            SLT:  res_lo = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            SLTU: res_lo = {{(WIDTH-1){1'b0}}, a_q < b_q};
            MULU: begin
                res_lo = iter_lo;
                res_hi = iter_hi;
            end
`ifdef SEQ_ALU_DIV_EN
            // Zero divisor: quotient all ones, remainder is the dividend.
            DIVU, REMU: begin
                res_div0 = (b_q == '0);
                res_lo   = res_div0 ? '1 : iter_lo;
                res_hi   = res_div0 ? a_q : iter_hi;
                if (op_q == REMU) begin
                    res_lo = res_div0 ? a_q : iter_hi;
                    res_hi = res_div0 ? '1 : iter_lo;
                end
            end
`endif
            default: res_lo = '0;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        out_hi_d = out_hi_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        if ((state_q == EXEC) && (state_d == DONE)) begin
            out_d    = res_lo;
            out_hi_d = res_hi;
            neg_d    = res_lo[WIDTH-1];
            zero_d   = (res_lo == '0);
            ovf_d    = res_ovf;
            div0_d   = res_div0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= SLL;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases plus random ops
// against an arithmetic reference model; honours SEQ_ALU_DIV_EN.
module tb_seq_alu;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] porta = '0;
    logic [31:0] portb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out, out_hi;
    logic        negative, zero, overflow, div0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .porta     (porta),
        .portb     (portb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .div0      (div0)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model from plain arithmetic; lat counts edges from accept.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic v, output logic d0, output int lat);
        longint sa, sb, r;
        logic [63:0] p;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        lo = '0; hi = '0; v = 1'b0; d0 = 1'b0; lat = 2;
        case (o)
            SLL:  lo = 32'(64'(a) * (64'd1 << sh));
            SRL:  lo = a / (32'd1 << sh);
            SRA:  lo = 32'(sa >>> sh);
            ADD:  begin r = sa + sb; lo = 32'(r); v = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            SUB:  begin r = sa - sb; lo = 32'(r); v = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            AND:  lo = a & b;
            OR:   lo = a | b;
            XOR:  lo = a ^ b;
            NOR:  lo = ~(a | b);
            SLT:  lo = (sa < sb) ? 32'd1 : 32'd0;
            SLTU: lo = (a < b) ? 32'd1 : 32'd0;
            MULU: begin p = 64'(a) * 64'(b); lo = p[31:0]; hi = p[63:32]; lat = 33; end
`ifdef SEQ_ALU_DIV_EN
            DIVU: begin lat = 33; d0 = (b == 0);
                lo = d0 ? 32'hFFFF_FFFF : a / b; hi = d0 ? a : a % b; end
            REMU: begin lat = 33; d0 = (b == 0);
                lo = d0 ? a : a % b; hi = d0 ? 32'hFFFF_FFFF : a / b; end
`endif
            default: lo = '0;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] elo, ehi;
        logic ev, ed, stable, rdy_low;
        logic [67:0] snap;
        int elat, cyc;
        model(o, a, b, elo, ehi, ev, ed, elat);
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; op = o; porta = a; portb = b;
        tick();
        in_valid = 1'b0; op = 4'($urandom); porta = $urandom; portb = $urandom;
        cyc = 1; rdy_low = 1'b1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            out_ready = (hold == 0) ? 1'($urandom) : 1'b0;
            tick();
            cyc++;
        end
        chk("latency", cyc, elat);
        chk("in_ready_busy", rdy_low && (in_ready === 1'b0), 1'b1);
        chk("out", out, elo);
        chk("out_hi", out_hi, ehi);
        chk("flags_nzvd", {negative, zero, overflow, div0}, {elo[31], elo == 0, ev, ed});
        if (hold > 0) begin
            out_ready = 1'b0;
            snap = {out, out_hi, negative, zero, overflow, div0};
            stable = 1'b1;
            in_valid = 1'b1; op = ADD; porta = $urandom; portb = $urandom;
            repeat (hold) begin
                tick();
                if ({out, out_hi, negative, zero, overflow, div0} !== snap ||
                    out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk("hold_stable", stable, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        repeat (3) tick();
        chk("reset_hs", {in_ready, out_valid}, 2'b10);
        chk("reset_out", {out, out_hi}, 64'd0);
        chk("reset_flags", {negative, zero, overflow, div0}, 4'd0);
        RST = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_out_ready", {in_ready, out_valid}, 2'b10);

        do_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(SUB, 32'd5, 32'd5, 0);
        do_op(SLT, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(DIVU, 32'd100, 32'd7, 0);
        do_op(DIVU, 32'd9, 32'd0, 0);
        do_op(REMU, 32'd100, 32'd7, 0);
        do_op(SUB, 32'h8000_0000, 32'h1, 0);
        do_op(SRA, 32'h8000_00F0, 32'd4, 0);
        do_op(4'd15, 32'h1234, 32'h5678, 0);
        do_op(XOR, 32'hDEAD_BEEF, 32'h1234_5678, 10);

        in_valid = 1'b1; op = MULU; porta = 32'hFFFF_0000; portb = 32'h0001_2345;
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_hs", {in_ready, out_valid}, 2'b10);
        chk("rst_mid_out", {out, out_hi}, 64'd0);
        chk("rst_mid_flags", {negative, zero, overflow, div0}, 4'd0);
        repeat (30) tick();
        chk("rst_no_result", out_valid, 1'b0);
        do_op(ADD, 32'd2, 32'd3, 0);

        for (int i = 0; i < 48; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 8 == 0) rb = 32'd0;
            do_op(ro, ra, rb, (i % 7 == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
